// File: rtl/dec_rv_ssc_pkg.sv
// dec_rv_ssc_pkg
// Shared definitions for the superscalar bundle former: RV32 major opcode
// values (instr[6:2]), per-op flag bit positions, funct7 values that
// qualify OP/OP-32, the bundle-width encoding and a register hazard helper.
// No ports (package).
package dec_rv_ssc_pkg;

    localparam logic [4:0] OPC_LOAD    = 5'b00000;
    localparam logic [4:0] OPC_STORE   = 5'b01000;
    localparam logic [4:0] OPC_BRANCH  = 5'b11000;
    localparam logic [4:0] OPC_JALR    = 5'b11001;
    localparam logic [4:0] OPC_JAL     = 5'b11011;
    localparam logic [4:0] OPC_OPIMM   = 5'b00100;
    localparam logic [4:0] OPC_OP      = 5'b01100;
    localparam logic [4:0] OPC_AUIPC   = 5'b00101;
    localparam logic [4:0] OPC_LUI     = 5'b01101;
    localparam logic [4:0] OPC_OPIMM32 = 5'b00110;
    localparam logic [4:0] OPC_OP32    = 5'b01110;

    // Flag bit positions inside each op's 4-bit capability nibble
    localparam int FLAG_L1_WITH_L2 = 0;
    localparam int FLAG_L1_WITH_L3 = 1;
    localparam int FLAG_L2_CAPABLE = 2;
    localparam int FLAG_L3_CAPABLE = 3;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef enum logic [1:0] {
        BW_NONE  = 2'd0,
        BW_ONE   = 2'd1,
        BW_TWO   = 2'd2,
        BW_THREE = 2'd3
    } bundle_w_e;

    // True when a younger op reads (RAW) or rewrites (WAW) the register an
    // older op writes. x0 is a constant, so it never creates a dependency.
    function automatic logic op_hazard(
        input logic [4:0] prod_rd,
        input logic       prod_wr,
        input logic [4:0] cons_rd,
        input logic [4:0] cons_rs1,
        input logic [4:0] cons_rs2,
        input logic       cons_wr,
        input logic       cons_r1,
        input logic       cons_r2
    );
        if (!prod_wr || prod_rd == 5'd0) begin
            return 1'b0;
        end
        return (cons_r1 && cons_rs1 == prod_rd) ||
               (cons_r2 && cons_rs2 == prod_rd) ||
               (cons_wr && cons_rd  == prod_rd);
    endfunction

endpackage

// File: rtl/dec_rv_ssc_if.sv
// dec_rv_ssc_if
// Fetch-window / bundle-result bus between pre-decode (master) and the
// bundle former (slave).
//   istrWin   : NLANES*32 fetch window, op0 in the low word
//   istrVld   : window valid
//   outFlags  : NLANES*4 registered per-op capability flags
//   outBundle : registered issue width 0..NLANES
//   outVld    : registered valid
//   outLdUse  : registered load-use hit on op0
interface dec_rv_ssc_if
    import dec_rv_ssc_pkg::*;
#(
    parameter int NLANES = 3
);
    logic [NLANES*32-1:0] istrWin;
    logic                 istrVld;
    logic [NLANES*4-1:0]  outFlags;
    logic [1:0]           outBundle;
    logic                 outVld;
    logic                 outLdUse;

    modport master (
        output istrWin, istrVld,
        input  outFlags, outBundle, outVld, outLdUse
    );

    modport slave (
        input  istrWin, istrVld,
        output outFlags, outBundle, outVld, outLdUse
    );
endinterface

// File: rtl/dec_rv_ssc_op_class.sv
// dec_rv_ssc_op_class
// Combinational classifier for one 32-bit instruction word.
// Optional feature macro: DEC_RV_SSC_MEXT_EN (M-extension ops become
// lane1-only co-issuable instead of forcing a single-wide bundle).
//   instr    : instruction word
//   flags    : capability nibble (bit0 L1+L2, bit1 L1+L3, bit2 L2, bit3 L3)
//   rd/rs1/rs2 : register fields
//   uses_rd/uses_rs1/uses_rs2 : whether each field is really used
//   is_load  : word is a LOAD
module dec_rv_ssc_op_class
    import dec_rv_ssc_pkg::*;
#(
    parameter int NLANES = 3
) (
    input  logic [31:0] instr,
    output logic [3:0]  flags,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        uses_rd,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        is_load
);

    logic [4:0] opcode;
    logic [6:0] funct7;
    logic       is_full;

    assign opcode  = instr[6:2];
    assign funct7  = instr[31:25];
    assign is_full = (instr[1:0] == 2'b11);
    assign rd      = instr[11:7];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];

    // Compressed words are not decoded here; they report no register use
    // and no capability, which keeps them alone in lane 1.
    always_comb begin
        flags    = 4'b0000;
        uses_rd  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        is_load  = 1'b0;
        if (is_full) begin
            uses_rd  = 1'b1;
            uses_rs1 = 1'b1;
            case (opcode)
                OPC_LOAD: begin
                    flags   = 4'b0011;
                    is_load = 1'b1;
                end
                OPC_STORE: begin
                    uses_rd  = 1'b0;
                    uses_rs2 = 1'b1;
                end
                OPC_BRANCH: begin
                    uses_rd  = 1'b0;
                    uses_rs2 = 1'b1;
                end
                OPC_JAL, OPC_AUIPC: begin
                    uses_rs1 = 1'b0;
                end
                OPC_LUI: begin
                    flags    = 4'b1111;
                    uses_rs1 = 1'b0;
                end
                OPC_OPIMM, OPC_OPIMM32: begin
                    flags = 4'b1111;
                end
                OPC_OP, OPC_OP32: begin
                    uses_rs2 = 1'b1;
                    if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                        flags = 4'b1111;
                    end
`ifdef DEC_RV_SSC_MEXT_EN
                    else if (funct7 == F7_MULDIV) begin
                        flags = 4'b0011;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
        // A two-lane machine has no third lane to advertise
        if (NLANES == 2) begin
            flags[FLAG_L1_WITH_L3] = 1'b0;
            flags[FLAG_L3_CAPABLE] = 1'b0;
        end
    end

endmodule

// File: rtl/dec_rv_ssc_bundle.sv
// dec_rv_ssc_bundle
// Registered superscalar bundle former. Classifies NLANES words, checks
// intra-bundle RAW/WAW and load-use against the previous bundle's op0,
// and registers the issue width. Keeps saturating width counters.
// Optional feature macro: DEC_RV_SSC_MEXT_EN (handled in op_class).
//   clock, reset  : core clock, asynchronous active-low reset
//   bus (slave)   : istrWin/istrVld in, outFlags/outBundle/outVld/outLdUse out
//   exHold        : stall, every register holds (perfClr still acts)
//   perfClr       : synchronous clear of the counters
//   perfCnt1/2/3  : counts of 1/2/3-wide bundles
module dec_rv_ssc_bundle
    import dec_rv_ssc_pkg::*;
#(
    parameter int NLANES = 3,
    parameter int CNTW   = 32
) (
    input  logic            clock,
    input  logic            reset,
    dec_rv_ssc_if.slave     bus,
    input  logic            exHold,
    input  logic            perfClr,
    output logic [CNTW-1:0] perfCnt1,
    output logic [CNTW-1:0] perfCnt2,
    output logic [CNTW-1:0] perfCnt3
);

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    // Arrays are sized for three lanes; absent lanes read as inert ops
    logic [3:0] op_flags [3];
    logic [4:0] op_rd    [3];
    logic [4:0] op_rs1   [3];
    logic [4:0] op_rs2   [3];
    logic       op_wr    [3];
    logic       op_r1    [3];
    logic       op_r2    [3];
    logic       op_load  [3];

    for (genvar k = 0; k < 3; k++) begin : g_lane
        if (k < NLANES) begin : g_op
            dec_rv_ssc_op_class #(.NLANES(NLANES)) u_class (
                .instr    (bus.istrWin[32*k +: 32]),
                .flags    (op_flags[k]),
                .rd       (op_rd[k]),
                .rs1      (op_rs1[k]),
                .rs2      (op_rs2[k]),
                .uses_rd  (op_wr[k]),
                .uses_rs1 (op_r1[k]),
                .uses_rs2 (op_r2[k]),
                .is_load  (op_load[k])
            );
        end else begin : g_none
            assign op_flags[k] = 4'b0000;
            assign op_rd[k]    = 5'd0;
            assign op_rs1[k]   = 5'd0;
            assign op_rs2[k]   = 5'd0;
            assign op_wr[k]    = 1'b0;
            assign op_r1[k]    = 1'b0;
            assign op_r2[k]    = 1'b0;
            assign op_load[k]  = 1'b0;
        end
    end

    logic [NLANES*4-1:0] flags_q, flags_d, win_flags;
    logic [1:0]          bundle_q, bundle_d;
    logic                vld_q, vld_d;
    logic                ld_use_q, ld_use_d;
    logic [4:0]          ld_rd_q, ld_rd_d;
    logic [CNTW-1:0]     cnt1_q, cnt1_d, cnt2_q, cnt2_d, cnt3_q, cnt3_d;

    logic      haz10, haz20, haz21, ld_use, can2, can3;
    bundle_w_e width;

    // Width decision: each extra lane needs the pairing flags plus freedom
    // from dependencies on every older op in the bundle. A load-use stall
    // on op0 always collapses the bundle to one.
    always_comb begin
        win_flags = '0;
        for (int k = 0; k < NLANES; k++) begin
            win_flags[4*k +: 4] = op_flags[k];
        end
        haz10 = op_hazard(op_rd[0], op_wr[0], op_rd[1], op_rs1[1], op_rs2[1],
                          op_wr[1], op_r1[1], op_r2[1]);
        haz20 = op_hazard(op_rd[0], op_wr[0], op_rd[2], op_rs1[2], op_rs2[2],
                          op_wr[2], op_r1[2], op_r2[2]);
        haz21 = op_hazard(op_rd[1], op_wr[1], op_rd[2], op_rs1[2], op_rs2[2],
                          op_wr[2], op_r1[2], op_r2[2]);
        ld_use = (ld_rd_q != 5'd0) &&
                 ((op_r1[0] && op_rs1[0] == ld_rd_q) ||
                  (op_r2[0] && op_rs2[0] == ld_rd_q));
        can2 = op_flags[0][FLAG_L1_WITH_L2] && op_flags[1][FLAG_L2_CAPABLE] && !haz10;
        can3 = (NLANES == 3) && can2 && op_flags[0][FLAG_L1_WITH_L3] &&
               op_flags[2][FLAG_L3_CAPABLE] && !haz20 && !haz21;
        if (ld_use) begin
            width = BW_ONE;
        end else if (can3) begin
            width = BW_THREE;
        end else if (can2) begin
            width = BW_TWO;
        end else begin
            width = BW_ONE;
        end
    end

    // Next-state: a stall freezes everything except the counter clear,
    // which deliberately overrides any increment in the same cycle.
    always_comb begin
        flags_d  = flags_q;
        bundle_d = bundle_q;
        vld_d    = vld_q;
        ld_use_d = ld_use_q;
        ld_rd_d  = ld_rd_q;
        cnt1_d   = cnt1_q;
        cnt2_d   = cnt2_q;
        cnt3_d   = cnt3_q;
        if (!exHold) begin
            if (bus.istrVld) begin
                flags_d  = win_flags;
                bundle_d = width;
                vld_d    = 1'b1;
                ld_use_d = ld_use;
                ld_rd_d  = op_load[0] ? op_rd[0] : 5'd0;
                case (width)
                    BW_ONE:   if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_ONE;
                    BW_TWO:   if (cnt2_q != '1) cnt2_d = cnt2_q + CNT_ONE;
                    BW_THREE: if (cnt3_q != '1) cnt3_d = cnt3_q + CNT_ONE;
                    default: begin
                    end
                endcase
            end else begin
                flags_d  = '0;
                bundle_d = 2'd0;
                vld_d    = 1'b0;
                ld_use_d = 1'b0;
            end
        end
        if (perfClr) begin
            cnt1_d = '0;
            cnt2_d = '0;
            cnt3_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flags_q  <= '0;
            bundle_q <= 2'd0;
            vld_q    <= 1'b0;
            ld_use_q <= 1'b0;
            ld_rd_q  <= 5'd0;
            cnt1_q   <= '0;
            cnt2_q   <= '0;
            cnt3_q   <= '0;
        end else begin
            flags_q  <= flags_d;
            bundle_q <= bundle_d;
            vld_q    <= vld_d;
            ld_use_q <= ld_use_d;
            ld_rd_q  <= ld_rd_d;
            cnt1_q   <= cnt1_d;
            cnt2_q   <= cnt2_d;
            cnt3_q   <= cnt3_d;
        end
    end

    assign bus.outFlags  = flags_q;
    assign bus.outBundle = bundle_q;
    assign bus.outVld    = vld_q;
    assign bus.outLdUse  = ld_use_q;
    assign perfCnt1      = cnt1_q;
    assign perfCnt2      = cnt2_q;
    assign perfCnt3      = cnt3_q;

endmodule

// File: tb/tb_dec_rv_ssc_bundle.sv
// tb_dec_rv_ssc_bundle
// Directed bench for dec_rv_ssc_bundle with NLANES=3, CNTW=4 (small
// counters so saturation is reachable). Windows are written {op2,op1,op0}.
module tb_dec_rv_ssc_bundle;

    localparam int NLANES = 3;
    localparam int CNTW   = 4;

    // ADDI x1,x2,5 / ADD x3,x4,x5 / ADDI x9,x1,1
    localparam logic [95:0] WIN_A   = {32'h00108493, 32'h005201B3, 32'h00510093};
    // LW x6,0(x7) / ADD x3,x4,x5 / ADDI x1,x2,5
    localparam logic [95:0] WIN_B   = {32'h00510093, 32'h005201B3, 32'h0003A303};
    // ADDI x8,x6,1 / ADD x3,x4,x5 / ADDI x1,x2,5
    localparam logic [95:0] WIN_C   = {32'h00510093, 32'h005201B3, 32'h00130413};
    // ADDI x1,x2,5 / SUB x3,x4,x5 / ADDI x9,x1,1
    localparam logic [95:0] WIN_SUB = {32'h00108493, 32'h405201B3, 32'h00510093};
    // ADDI x1,x2,5 / MUL x3,x4,x5 / ADDI x9,x1,1
    localparam logic [95:0] WIN_MUL = {32'h00108493, 32'h025201B3, 32'h00510093};
    // ADDI x1,x2,5 / ADDI x1,x2,5 / NOP  (op1 rewrites op0's rd)
    localparam logic [95:0] WIN_WAW = {32'h00000013, 32'h00510093, 32'h00510093};
    // three NOPs, all writing x0
    localparam logic [95:0] WIN_NOP = {32'h00000013, 32'h00000013, 32'h00000013};
    // compressed op0 (c.li) / ADD / ADDI
    localparam logic [95:0] WIN_CMP = {32'h00510093, 32'h005201B3, 32'h00004505};

`ifdef DEC_RV_SSC_MEXT_EN
    localparam logic [11:0] MUL_FLAGS = 12'hF3F;
`else
    localparam logic [11:0] MUL_FLAGS = 12'hF0F;
`endif

    logic            clock;
    logic            reset;
    logic            exHold;
    logic            perfClr;
    logic [CNTW-1:0] perfCnt1, perfCnt2, perfCnt3;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    dec_rv_ssc_if #(.NLANES(NLANES)) bus ();

    dec_rv_ssc_bundle #(.NLANES(NLANES), .CNTW(CNTW)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .exHold   (exHold),
        .perfClr  (perfClr),
        .perfCnt1 (perfCnt1),
        .perfCnt2 (perfCnt2),
        .perfCnt3 (perfCnt3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs and return 1 time unit after the edge
    task automatic apply_stimulus(input logic [95:0] win, input logic vld,
                                  input logic hold, input logic clr);
        bus.istrWin = win;
        bus.istrVld = vld;
        exHold      = hold;
        perfClr     = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [11:0] flags,
                              input logic [1:0] bundle, input logic vld,
                              input logic lu);
        check_output({tag, ".flags"},  32'(bus.outFlags),  32'(flags));
        check_output({tag, ".bundle"}, 32'(bus.outBundle), 32'(bundle));
        check_output({tag, ".vld"},    32'(bus.outVld),    32'(vld));
        check_output({tag, ".lduse"},  32'(bus.outLdUse),  32'(lu));
    endtask

    task automatic check_cnts(input string tag, input logic [3:0] c1,
                              input logic [3:0] c2, input logic [3:0] c3);
        check_output({tag, ".cnt1"}, 32'(perfCnt1), 32'(c1));
        check_output({tag, ".cnt2"}, 32'(perfCnt2), 32'(c2));
        check_output({tag, ".cnt3"}, 32'(perfCnt3), 32'(c3));
    endtask

    initial begin
        reset       = 1'b1;
        bus.istrWin = '0;
        bus.istrVld = 1'b0;
        exHold      = 1'b0;
        perfClr     = 1'b0;
        #1 reset = 1'b0;
        #1;
        check_outs("reset", 12'h000, 2'd0, 1'b0, 1'b0);
        check_cnts("reset", 4'd0, 4'd0, 4'd0);
        #6 reset = 1'b1;

        apply_stimulus(WIN_A, 1'b1, 1'b0, 1'b0);
        check_outs("raw_op2", 12'hFFF, 2'd2, 1'b1, 1'b0);
        check_cnts("raw_op2", 4'd0, 4'd1, 4'd0);

        apply_stimulus(WIN_B, 1'b1, 1'b0, 1'b0);
        check_outs("load3", 12'hFF3, 2'd3, 1'b1, 1'b0);
        check_cnts("load3", 4'd0, 4'd1, 4'd1);

        apply_stimulus(WIN_C, 1'b1, 1'b0, 1'b0);
        check_outs("lduse", 12'hFFF, 2'd1, 1'b1, 1'b1);
        check_cnts("lduse", 4'd1, 4'd1, 4'd1);

        apply_stimulus(WIN_SUB, 1'b1, 1'b0, 1'b0);
        check_outs("sub", 12'hFFF, 2'd2, 1'b1, 1'b0);

        apply_stimulus(WIN_MUL, 1'b1, 1'b0, 1'b0);
        check_outs("mul", MUL_FLAGS, 2'd1, 1'b1, 1'b0);

        apply_stimulus(WIN_WAW, 1'b1, 1'b0, 1'b0);
        check_outs("waw", 12'hFFF, 2'd1, 1'b1, 1'b0);

        apply_stimulus(WIN_NOP, 1'b1, 1'b0, 1'b0);
        check_outs("x0", 12'hFFF, 2'd3, 1'b1, 1'b0);
        check_cnts("x0", 4'd3, 4'd2, 4'd2);

        // Stall: load in flight, then three held cycles with changing windows
        apply_stimulus(WIN_B, 1'b1, 1'b0, 1'b0);
        apply_stimulus(WIN_C, 1'b1, 1'b1, 1'b0);
        check_outs("hold1", 12'hFF3, 2'd3, 1'b1, 1'b0);
        apply_stimulus(WIN_A, 1'b1, 1'b1, 1'b0);
        check_outs("hold2", 12'hFF3, 2'd3, 1'b1, 1'b0);
        apply_stimulus(WIN_C, 1'b0, 1'b1, 1'b0);
        check_outs("hold3", 12'hFF3, 2'd3, 1'b1, 1'b0);
        check_cnts("hold3", 4'd3, 4'd2, 4'd3);
        apply_stimulus(WIN_C, 1'b1, 1'b0, 1'b0);
        check_outs("unhold", 12'hFFF, 2'd1, 1'b1, 1'b1);
        check_cnts("unhold", 4'd4, 4'd2, 4'd3);

        // Invalid window leaves the load register untouched
        apply_stimulus(WIN_B, 1'b1, 1'b0, 1'b0);
        apply_stimulus(WIN_C, 1'b0, 1'b0, 1'b0);
        check_outs("novld", 12'h000, 2'd0, 1'b0, 1'b0);
        check_cnts("novld", 4'd4, 4'd2, 4'd4);
        apply_stimulus(WIN_C, 1'b1, 1'b0, 1'b0);
        check_outs("novld_lduse", 12'hFFF, 2'd1, 1'b1, 1'b1);

        apply_stimulus(WIN_CMP, 1'b1, 1'b0, 1'b0);
        check_outs("compressed", 12'hFF0, 2'd1, 1'b1, 1'b0);
        check_cnts("compressed", 4'd6, 4'd2, 4'd4);

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(WIN_MUL, 1'b1, 1'b0, 1'b0);
        end
        check_cnts("sat_reach", 4'd15, 4'd2, 4'd4);
        apply_stimulus(WIN_MUL, 1'b1, 1'b0, 1'b0);
        check_cnts("sat_hold", 4'd15, 4'd2, 4'd4);

        apply_stimulus(WIN_A, 1'b1, 1'b0, 1'b1);
        check_outs("clr_inc", 12'hFFF, 2'd2, 1'b1, 1'b0);
        check_cnts("clr_inc", 4'd0, 4'd0, 4'd0);
        apply_stimulus(WIN_A, 1'b1, 1'b0, 1'b0);
        check_cnts("after_clr", 4'd0, 4'd1, 4'd0);
        apply_stimulus(WIN_B, 1'b1, 1'b1, 1'b1);
        check_outs("clr_hold", 12'hFFF, 2'd2, 1'b1, 1'b0);
        check_cnts("clr_hold", 4'd0, 4'd0, 4'd0);

        // Asynchronous reset between edges, after a load was issued
        apply_stimulus(WIN_B, 1'b1, 1'b0, 1'b0);
        check_outs("pre_reset", 12'hFF3, 2'd3, 1'b1, 1'b0);
        #3 reset = 1'b0;
        #1;
        check_outs("mid_reset", 12'h000, 2'd0, 1'b0, 1'b0);
        check_cnts("mid_reset", 4'd0, 4'd0, 4'd0);
        #1 reset = 1'b1;
        apply_stimulus(WIN_C, 1'b1, 1'b0, 1'b0);
        check_outs("post_reset", 12'hFFF, 2'd3, 1'b1, 1'b0);
        check_cnts("post_reset", 4'd0, 4'd0, 4'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
